// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN_CPU = 2'd1,
      ST_OWN_DBG = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DBG = 1'b1
   } owner_e;

   localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/arb_port_mux.sv
// Routes the granted port's address, write data and strobes onto the memory bus.
module arb_port_mux #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              cpu_gnt,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              dbg_gnt,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr
);

   // Bus stays fully zero whenever nobody holds a grant.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wr    = cpu_we;
         mem_rd    = !cpu_we;
      end else if (dbg_gnt) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_wr    = dbg_we;
         mem_rd    = !dbg_we;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / debug-loader memory arbiter with bounded bursts and 1-cycle read return.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin IDLE tie-break (default: CPU priority).
//
// state      | meaning
// ST_IDLE    | no owner, bus idle
// ST_OWN_CPU | CPU owns the bus, granted while cpu_req
// ST_OWN_DBG | debug port owns the bus, granted while dbg_req
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [BURST_CNT_W:0]   MAX_BURST_X = (BURST_CNT_W+1)'(MAX_BURST);
   localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

   arb_state_e             state_q, state_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [BURST_CNT_W:0]   burst_incl;
   logic                   burst_hit;
   logic                   tie_cpu;
   logic                   cpu_rvalid_q, cpu_rvalid_d;
   logic                   dbg_rvalid_q, dbg_rvalid_d;

   assign cpu_gnt   = (state_q == ST_OWN_CPU) && cpu_req;
   assign dbg_gnt   = (state_q == ST_OWN_DBG) && dbg_req;
   assign cpu_stall = cpu_req && !cpu_gnt;

   // Count includes this cycle's access so the limit hands over right after the Nth grant.
   assign burst_incl = {1'b0, burst_cnt_q} + {{BURST_CNT_W{1'b0}}, (cpu_gnt | dbg_gnt)};
   assign burst_hit  = (burst_incl >= MAX_BURST_X);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_e last_owner_q, last_owner_d;

   assign tie_cpu = (last_owner_q == OWNER_DBG);

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_d != state_q) begin
         if (state_d == ST_OWN_CPU)      last_owner_d = OWNER_CPU;
         else if (state_d == ST_OWN_DBG) last_owner_d = OWNER_DBG;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_owner_q <= OWNER_DBG;
      else     last_owner_q <= last_owner_d;
   end
`else
   assign tie_cpu = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req && dbg_req) state_d = tie_cpu ? ST_OWN_CPU : ST_OWN_DBG;
            else if (cpu_req)       state_d = ST_OWN_CPU;
            else if (dbg_req)       state_d = ST_OWN_DBG;
         end
         ST_OWN_CPU: begin
            if (!cpu_req)                state_d = dbg_req ? ST_OWN_DBG : ST_IDLE;
            else if (burst_hit && dbg_req) state_d = ST_OWN_DBG;
         end
         ST_OWN_DBG: begin
            if (!dbg_req)                state_d = cpu_req ? ST_OWN_CPU : ST_IDLE;
            else if (burst_hit && cpu_req) state_d = ST_OWN_CPU;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if ((state_d != state_q) || (state_d == ST_IDLE)) burst_cnt_d = '0;
      else if (burst_hit)                               burst_cnt_d = MAX_BURST_C;
      else                                              burst_cnt_d = burst_incl[BURST_CNT_W-1:0];
   end

   always_comb begin
      cpu_rvalid_d = cpu_gnt && !cpu_we;
      dbg_rvalid_d = dbg_gnt && !dbg_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         burst_cnt_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
      end
   end

   assign cpu_rvalid = cpu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
   assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : '0;

   arb_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_port_mux (
      .cpu_gnt   (cpu_gnt),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .dbg_gnt   (dbg_gnt),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-return scoreboard and per-cycle invariants.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk, rst;
   logic       cpu_req, cpu_we, dbg_req, dbg_we;
   logic [4:0] cpu_addr, dbg_addr, mem_addr;
   logic [7:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic       cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] tb_mem [32];
   logic [7:0] cpu_q [$];
   logic [7:0] dbg_q [$];
   logic       cpu_pend, dbg_pend;

   mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] init_val(input int i);
      return (i == 3) ? 8'hA5 : 8'(i * 29 + 1);
   endfunction

   // Synchronous memory: read data one cycle after mem_rd, contents reloaded on reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
      end else if (mem_wr) begin
         tb_mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem_rd ? tb_mem[mem_addr] : 8'h00;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic ec, input logic ed);
      @(negedge clk);
      chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'(ec));
      chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'(ed));
      @(posedge clk);
      #1;
   endtask

   // Invariants and read-return scoreboard, sampled on the falling edge.
   initial begin
      cpu_pend = 1'b0;
      dbg_pend = 1'b0;
      forever begin
         @(negedge clk);
         chk("gnt_onehot", 32'(cpu_gnt & dbg_gnt), 32'd0);
         chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
         chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_gnt));
         if (!cpu_gnt && !dbg_gnt)
            chk("mem_idle", 32'({mem_addr, mem_wdata, mem_rd, mem_wr}), 32'd0);
         if (rst) begin
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
            cpu_pend = 1'b0;
            dbg_pend = 1'b0;
            cpu_q.delete();
            dbg_q.delete();
         end else begin
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(cpu_pend));
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(dbg_pend));
            if (cpu_rvalid && cpu_q.size() > 0) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
            else if (!cpu_rvalid)               chk("cpu_rdata_zero", 32'(cpu_rdata), 32'd0);
            if (dbg_rvalid && dbg_q.size() > 0) chk("dbg_rdata", 32'(dbg_rdata), 32'(dbg_q.pop_front()));
            else if (!dbg_rvalid)               chk("dbg_rdata_zero", 32'(dbg_rdata), 32'd0);
            cpu_pend = cpu_gnt && !cpu_we;
            dbg_pend = dbg_gnt && !dbg_we;
            if (cpu_pend) cpu_q.push_back(tb_mem[cpu_addr]);
            if (dbg_pend) dbg_q.push_back(tb_mem[dbg_addr]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // Reset state: no grants or strobes, stall follows cpu_req.
      @(negedge clk);
      chk("rst_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd1);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // CPU read of address 3.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
      @(negedge clk);
      chk("s1_gnt_first", 32'(cpu_gnt), 32'd0);
      chk("s1_stall_first", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s1_gnt", 32'(cpu_gnt), 32'd1);
      chk("s1_stall", 32'(cpu_stall), 32'd0);
      chk("s1_mem_rd", 32'(mem_rd), 32'd1);
      chk("s1_mem_addr", 32'(mem_addr), 32'h03);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      chk("s1_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("s1_rdata", 32'(cpu_rdata), 32'hA5);
      cyc("s1_drop", 1'b0, 1'b0);
      cyc("s1_idle", 1'b0, 1'b0);

      // Simultaneous requests after reset, then again from IDLE.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
      cyc("s2a_idle", 1'b0, 1'b0);
      cyc("s2a_first", 1'b1, 1'b0);
      cpu_req = 1'b0; dbg_req = 1'b0;
      cyc("s2a_drop", 1'b0, 1'b0);
      cpu_req = 1'b1; dbg_req = 1'b1;
      cyc("s2b_idle", 1'b0, 1'b0);
      cyc("s2b_first", !RR, RR);
      cpu_req = 1'b0; dbg_req = 1'b0;
      cyc("s2b_drop", 1'b0, 1'b0);
      cyc("s2b_idle2", 1'b0, 1'b0);

      // DBG write burst interrupted by a CPU read after MAX_BURST accesses.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 8'h10;
      cyc("s3_idle", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc("s3_dbg", 1'b0, 1'b1);
         if (i == 0) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd20;
         end
         dbg_addr  = 5'(i + 1);
         dbg_wdata = 8'(8'h10 + i + 1);
      end
      cyc("s3_handover", 1'b1, 1'b0);
      cyc("s3_cpu2", 1'b1, 1'b0);
      cpu_req = 1'b0;
      cyc("s3_cpu_drop", 1'b0, 1'b0);
      for (int i = 4; i < 8; i++) begin
         cyc("s3_dbg_resume", 1'b0, 1'b1);
         dbg_addr  = 5'(i + 1);
         dbg_wdata = 8'(8'h10 + i + 1);
      end
      dbg_req = 1'b0;
      cyc("s3_end", 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) chk("s3_mem", 32'(tb_mem[i]), 32'(8'h10 + i));

      // DBG alone: 10 back-to-back writes, no handover.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd8; dbg_wdata = 8'h40;
      cyc("s4_idle", 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc("s4_dbg", 1'b0, 1'b1);
         dbg_addr  = 5'(8 + i + 1);
         dbg_wdata = 8'(8'h40 + i + 1);
      end
      dbg_req = 1'b0;
      cyc("s4_end", 1'b0, 1'b0);
      cyc("s4_idle2", 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) chk("s4_mem", 32'(tb_mem[8 + i]), 32'(8'h40 + i));

      // Reset asserted mid-read while the CPU owns the bus.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
      cyc("s5_idle", 1'b0, 1'b0);
      cyc("s5_rd1", 1'b1, 1'b0);
      #2;
      chk("s5_pre_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("s5_pre_gnt", 32'(cpu_gnt), 32'd1);
      rst = 1'b1;
      #1;
      chk("s5_rst_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      chk("s5_rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
      chk("s5_rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("s5_rst_rdata", 32'(cpu_rdata), 32'd0);
      chk("s5_rst_stall", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc("s5_post_idle", 1'b0, 1'b0);
      cyc("s5_post_gnt", 1'b1, 1'b0);
      cpu_req = 1'b0;
      cyc("s5_drop", 1'b0, 1'b0);
      cyc("s5_idle2", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
